seven_segment_decoder: RTL and testbench
========================================

// Module: seven_segment_decoder
// PURPOSE
//  Reverse of the two-digit seven-segment display encoder: samples a 14-bit
//  segment pattern (tens digit A1..G1, ones digit A2..G2) and recovers the
//  binary value 0..99, the overflow ("OV") indication or an error flag.
//  Used as a display monitor and loop-back checker beside the BCD count-up
//  display path; the output value only changes once the glitch filter accepts it.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before acceptance (>=1)
//  ACTIVE_LOW     0  1: segment inputs are active-low and are inverted at the sample stage
// PORTS
//  clk      in   1  rising-edge clock
//  Reset    in   1  asynchronous, active-high reset
//  seg_in   in   14 {A1,B1,C1,D1,E1,F1,G1,A2,B2,C2,D2,E2,F2,G2}; bit13=A1; synchronous to clk
//  value    out  7  decoded value 0..99 (binary); holds the last legal value
//  valid    out  1  last accepted pattern was a legal number
//  ovf      out  1  last accepted pattern was "OV"
//  err      out  1  last accepted pattern was illegal
//  upd      out  1  one-cycle pulse when an acceptance changes {value,valid,ovf,err}
//  step_err out  1  one-cycle pulse on an illegal count step (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): value=0, valid=0, ovf=0, err=0, upd=0, step_err=0, filter cleared.
//  - Sample reg s_q <= seg_in (inverted if ACTIVE_LOW) every edge.
//  - Run counter: s_q != previous s_q -> run=1; else run saturates at STABLE_CYCLES.
//  - Accept on the edge after run first reaches STABLE_CYCLES, once per stable run.
//    Latency, STABLE_CYCLES=4: seg_in settles before edge k; samples k..k+3 match;
//    outputs update at edge k+4. A shorter run never updates the outputs.
//  - Digit codes (ABCDEFG): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//    5=1011011 6=1011111 7=1110000 8=1111111 9=1111011. Blank=0000000.
//  - Classification of the accepted pattern:
//    tens blank + ones digit d          -> valid, value=d
//    tens digit t in 1..9 + ones digit d -> valid, value=10*t+d
//    14'b11111100111110 ("OV")          -> ovf=1, valid=0, value held
//    anything else (including tens '0' with any digit and tens blank + ones blank) -> err=1, valid=0, value held
//  - valid/ovf/err are mutually exclusive. Each acceptance updates all three.
//  - upd=1 for exactly one cycle when the new {value,valid,ovf,err} differs from the
//    held state. Re-accepting an identical pattern does not pulse upd.
//  - The multiply 10*t is combinational and fits 7 bits. value never exceeds 99.
//  - Reset mid-run discards the partial run. A run restarts on the first sample after release.
// CONFIGURATION
//  SEG_DEC_STEP_CHECK_EN defined: at an acceptance with upd=1 whose previous held
//   state was valid, step_err pulses with upd unless the new state is one of:
//   value=prev+1 (valid), prev=99 -> value=0 (wrap), value=0 (counter reset),
//   or prev=99 -> ovf. No step check applies from an ovf/err/reset state.
//  Not defined: the checker logic is absent and step_err is tied 0. The port remains.
// TESTING
//  1 Reset, then hold "00" pattern 14'b00000001111110 for 6 cycles -> valid=1, value=0,
//    upd pulse at edge 4 after settle (STABLE_CYCLES=4).
//  2 Apply 14'b11011011111001 ("23") for 3 cycles, then "57" -> the 23 is never accepted;
//    value=57, one upd pulse.
//  3 Apply "OV" 14'b11111100111110 after "42" -> ovf=1, valid=0, value stays 42.
//    Then apply 14'b00000000000000 -> err=1, ovf=0.
//  4 Sweep 0..99 then 0, each held 5 cycles -> 101 upd pulses, value tracks the count,
//    step_err never set (with _EN).
//  5 With _EN: sequence 17 -> 19 -> step_err pulses once with upd. Without _EN: step_err=0.
//  6 Assert Reset while a run is at run=3 -> all outputs 0 immediately. After release,
//    acceptance needs 4 new matching samples.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
//   Recovers the binary value 0..99, the "OV" indication or an error flag from a
//   two-digit seven-segment pattern. Each sample passes a glitch filter: a
//   pattern is accepted only after it has been sampled STABLE_CYCLES times in a
//   row, and it is accepted once per stable run.
//
//   Optional feature (macro SEG_DEC_STEP_CHECK_EN): count-step checker that
//   pulses step_err when a held legal value moves to anything other than
//   +1, wrap 99->0, reset to 0 or 99->OV. Without the macro step_err is tied 0.
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples required before acceptance (>=1)
//   ACTIVE_LOW     1: segment inputs are active-low and are inverted when sampled
//
// Ports
//   clk       rising-edge clock
//   Reset     asynchronous active-high reset
//   seg_in    {A1..G1,A2..G2}, bit13 = A1 (tens A segment)
//   value     decoded value 0..99, holds the last legal value
//   valid     last accepted pattern was a legal number
//   ovf       last accepted pattern was "OV"
//   err       last accepted pattern was illegal
//   upd       one-cycle pulse when an acceptance changes {value,valid,ovf,err}
//   step_err  one-cycle pulse on an illegal count step

module seven_segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [13:0] seg_in,
  output logic [6:0]  value,
  output logic        valid,
  output logic        ovf,
  output logic        err,
  output logic        upd,
  output logic        step_err
);

  localparam int unsigned SEG_W = 14;
  localparam int unsigned DIG_W = 7;
  localparam int unsigned VAL_W = 7;
  localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(STABLE_CYCLES);
  localparam logic [SEG_W-1:0] OV_PATTERN = 14'b11111100111110;

  // Segment code (ABCDEFG) to {legal, digit}
  function automatic logic [4:0] seg_to_digit(input logic [DIG_W-1:0] code);
    case (code)
      7'b1111110: return {1'b1, 4'd0};
      7'b0110000: return {1'b1, 4'd1};
      7'b1101101: return {1'b1, 4'd2};
      7'b1111001: return {1'b1, 4'd3};
      7'b0110011: return {1'b1, 4'd4};
      7'b1011011: return {1'b1, 4'd5};
      7'b1011111: return {1'b1, 4'd6};
      7'b1110000: return {1'b1, 4'd7};
      7'b1111111: return {1'b1, 4'd8};
      7'b1111011: return {1'b1, 4'd9};
      default:    return 5'd0;
    endcase
  endfunction

  logic [SEG_W-1:0] s_q,        s_d;
  logic [RUN_W-1:0] run_q,      run_d;
  logic             done_q,     done_d;
  logic [VAL_W-1:0] value_q,    value_d;
  logic             valid_q,    valid_d;
  logic             ovf_q,      ovf_d;
  logic             err_q,      err_d;
  logic             upd_q,      upd_d;

  logic             same;
  logic             fire;
  logic [4:0]       tens;
  logic [4:0]       ones;
  logic             tens_blank;
  logic             num_ok;
  logic [VAL_W-1:0] num_val;
  logic             is_ov;
  logic [VAL_W-1:0] n_value;
  logic             n_valid;
  logic             n_ovf;
  logic             n_err;
  logic             changed;

  // Sample, glitch filter and classification of the held sample
  always_comb begin
    s_d = ACTIVE_LOW ? ~seg_in : seg_in;

    // run_q == 0 only right after reset, so the first sample always opens a run
    same  = (s_d == s_q) && (run_q != '0);
    run_d = same ? ((run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1)) : RUN_W'(1);

    // Accept exactly once: on the edge after the run first saturates
    fire   = (run_q == RUN_MAX) && !done_q;
    done_d = !same ? 1'b0 : (fire ? 1'b1 : done_q);

    tens       = seg_to_digit(s_q[13:7]);
    ones       = seg_to_digit(s_q[6:0]);
    tens_blank = (s_q[13:7] == '0);
    // A tens '0' is never a legal leading digit
    num_ok     = ones[4] && (tens_blank || (tens[4] && (tens[3:0] != 4'd0)));
    num_val    = tens_blank ? VAL_W'(ones[3:0])
                            : VAL_W'(tens[3:0]) * VAL_W'(10) + VAL_W'(ones[3:0]);
    is_ov      = (s_q == OV_PATTERN);

    n_value = num_ok ? num_val : value_q;
    n_valid = num_ok;
    n_ovf   = !num_ok && is_ov;
    n_err   = !num_ok && !is_ov;
    changed = {n_value, n_valid, n_ovf, n_err} != {value_q, valid_q, ovf_q, err_q};

    value_d = value_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    upd_d   = 1'b0;
    if (fire) begin
      value_d = n_value;
      valid_d = n_valid;
      ovf_d   = n_ovf;
      err_d   = n_err;
      upd_d   = changed;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s_q     <= '0;
      run_q   <= '0;
      done_q  <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      run_q   <= run_d;
      done_q  <= done_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
    end
  end

`ifdef SEG_DEC_STEP_CHECK_EN
  logic step_ok;
  logic step_err_q, step_err_d;

  // Legal moves out of a valid state: +1, to 0 (covers 99->0 wrap), 99->OV
  always_comb begin
    step_ok    = (n_valid && (n_value == value_q + VAL_W'(1)))
              || (n_valid && (n_value == '0))
              || ((value_q == VAL_W'(99)) && n_ovf);
    step_err_d = fire && changed && valid_q && !step_ok;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      step_err_q <= 1'b0;
    end else begin
      step_err_q <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

  assign value = value_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign err   = err_q;
  assign upd   = upd_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder
//   Directed scenarios plus randomized segment patterns, checked each cycle
//   against a reference model that works on the sample history and decodes
//   by digit-table lookup and decimal arithmetic.

module tb_seven_segment_decoder;

  localparam int STABLE = 4;
  localparam logic [13:0] OV = 14'b11111100111110;
  localparam logic [6:0] DIG [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1111011};

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [13:0] seg_in = '0;
  logic [6:0]  value;
  logic        valid, ovf, err, upd, step_err;

  always #5 clk = ~clk;

  seven_segment_decoder dut (
    .clk      (clk),
    .Reset    (Reset),
    .seg_in   (seg_in),
    .value    (value),
    .valid    (valid),
    .ovf      (ovf),
    .err      (err),
    .upd      (upd),
    .step_err (step_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int step_cnt = 0;

  // Reference model state
  logic [13:0] hist[$];
  int m_value = 0;
  bit m_valid = 0, m_ovf = 0, m_err = 0, m_upd = 0, m_step = 0;

  function automatic logic [13:0] num_pat(input int n);
    logic [6:0] t;
    t = (n >= 10) ? DIG[n / 10] : 7'b0000000;
    return {t, DIG[n % 10]};
  endfunction

  function automatic int dig_of(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (DIG[i] == c) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_value = 0; m_valid = 0; m_ovf = 0; m_err = 0; m_upd = 0; m_step = 0;
  endtask

  // One clock edge of the reference: accept when the newest held pattern has
  // been seen exactly STABLE times in a row
  task automatic model_edge(input logic [13:0] p);
    int run, t, d, nv;
    logic [13:0] last;
    bit nvalid, novf, nerr, changed, ok;
    m_upd = 0; m_step = 0;
    if (hist.size() > 0) begin
      last = hist[hist.size()-1];
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] == last) run++;
        else break;
      end
      if (run == STABLE) begin
        t = dig_of(last[13:7]);
        d = dig_of(last[6:0]);
        nv = m_value; nvalid = 0; novf = 0; nerr = 0;
        if (d >= 0 && last[13:7] == 7'd0) begin nvalid = 1; nv = d; end
        else if (d >= 0 && t >= 1)       begin nvalid = 1; nv = 10 * t + d; end
        else if (last == OV)             novf = 1;
        else                             nerr = 1;
        changed = (nv != m_value) || (nvalid != m_valid) || (novf != m_ovf) || (nerr != m_err);
        ok = 0;
`ifdef SEG_DEC_STEP_CHECK_EN
        ok = (nvalid && nv == m_value + 1) || (nvalid && nv == 0) || (m_value == 99 && novf);
        m_step = changed && m_valid && !ok;
`endif
        m_upd = changed;
        m_value = nv; m_valid = nvalid; m_ovf = novf; m_err = nerr;
      end
    end
    hist.push_back(p);
    if (hist.size() > 2 * STABLE) void'(hist.pop_front());
  endtask

  // Drive one pattern for one cycle, then compare every output with the model
  task automatic tick(input logic [13:0] p);
    seg_in = p;
    @(posedge clk);
    model_edge(p);
    #1;
    chk("value", 32'(value), m_value);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("err", 32'(err), 32'(m_err));
    chk("upd", 32'(upd), 32'(m_upd));
    chk("step_err", 32'(step_err), 32'(m_step));
    if (upd === 1'b1) upd_cnt++;
    if (step_err === 1'b1) step_cnt++;
  endtask

  task automatic hold(input logic [13:0] p, input int n);
    for (int i = 0; i < n; i++) tick(p);
  endtask

  initial begin
    int kind, hn;
    logic [13:0] p;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_upd", 32'(upd), 0);
    chk("rst_step", 32'(step_err), 0);
    Reset = 1'b0;
    model_reset();

    // 1: "00" for 6 cycles, accepted on the 5th edge
    upd_cnt = 0;
    hold(14'b00000001111110, 4);
    chk("t1_not_yet", 32'(valid), 0);
    tick(14'b00000001111110);
    chk("t1_upd_edge", 32'(upd), 1);
    tick(14'b00000001111110);
    chk("t1_valid", 32'(valid), 1);
    chk("t1_value", 32'(value), 0);
    chk("t1_upd_cnt", upd_cnt, 1);

    // 2: short "23" run is filtered out, "57" is taken
    upd_cnt = 0;
    hold(14'b11011011111001, 3);
    hold(num_pat(57), 6);
    chk("t2_value", 32'(value), 57);
    chk("t2_upd_cnt", upd_cnt, 1);

    // 3: "42" -> OV -> all blank
    hold(num_pat(42), 6);
    hold(OV, 6);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_valid", 32'(valid), 0);
    chk("t3_value_held", 32'(value), 42);
    hold(14'b00000000000000, 6);
    chk("t3_err", 32'(err), 1);
    chk("t3_ovf_clr", 32'(ovf), 0);

    // 4: count sweep 0..99 then wrap to 0
    upd_cnt = 0; step_cnt = 0;
    for (int n = 0; n <= 100; n++) hold(num_pat(n % 100), 5);
    chk("t4_upd_cnt", upd_cnt, 101);
    chk("t4_step_cnt", step_cnt, 0);
    chk("t4_value", 32'(value), 0);

    // 5: 17 -> 19 is an illegal step
    hold(num_pat(17), 6);
    step_cnt = 0; upd_cnt = 0;
    hold(num_pat(19), 6);
    chk("t5_upd_cnt", upd_cnt, 1);
`ifdef SEG_DEC_STEP_CHECK_EN
    chk("t5_step_cnt", step_cnt, 1);
`else
    chk("t5_step_cnt", step_cnt, 0);
`endif

    // 6: reset in the middle of a run
    hold(num_pat(88), 3);
    Reset = 1'b1;
    #1;
    model_reset();
    chk("t6_value", 32'(value), 0);
    chk("t6_valid", 32'(valid), 0);
    chk("t6_upd", 32'(upd), 0);
    chk("t6_step", 32'(step_err), 0);
    #3 Reset = 1'b0;
    hold(num_pat(88), 4);
    chk("t6_no_early", 32'(valid), 0);
    tick(num_pat(88));
    chk("t6_valid_after", 32'(valid), 1);
    chk("t6_value_after", 32'(value), 88);

    // Randomized patterns with random hold lengths
    for (int s = 0; s < 200; s++) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        5:       p = OV;
        6:       p = 14'($urandom());
        7:       p = {DIG[$urandom_range(0, 9)], 7'($urandom())};
        default: p = num_pat(int'($urandom_range(0, 99)));
      endcase
      hn = int'($urandom_range(1, 7));
      hold(p, hn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
